imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Sequences and shares the 256 x 32 instruction memory between two requesters: the CPU fetch port (read-only) and the boot/debug loader port (read/write). After reset it holds the CPU in a BOOT state so the loader can write the program, then switches to RUN, where fetch has priority and a starvation counter guarantees the loader a slot. It drives a single-port, synchronous-read memory macro and returns read data with fixed one-cycle latency.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the memory (depth 2^ADDR_W).
- MAX_WAIT, 4, loader wait cycles in RUN before it preempts fetch for one grant (1..15).

Ports:
- CLK  in  1  rising-edge clock; the only clock.
- RST_n  in  1  asynchronous, active-low reset.
- FetchReq  in  1  CPU read request.
- FetchAddr  in  32  CPU byte address.
- FetchGnt  out  1  fetch accepted this cycle.
- FetchValid  out  1  FetchData valid (one cycle after FetchGnt).
- FetchData  out  32  read word.
- FetchErr  out  1  with FetchValid: misaligned or out-of-range access.
- CpuStall  out  1  high while CPU must not fetch (BOOT, or fetch request pending without grant).
- LdReq  in  1  loader request.
- LdWe  in  1  1 = write, 0 = read.
- LdAddr  in  32  loader byte address.
- LdWrData  in  32  write word.
- LdDone  in  1  one-cycle pulse: program loaded, leave BOOT.
- LdGnt  out  1  loader accepted this cycle.
- LdValid  out  1  LdRdData valid (one cycle after a read LdGnt).
- LdRdData  out  32  read word.
- LdErr  out  1  with LdValid, or one cycle after a write grant: bad address.
- MemEn  out  1  memory enable.
- MemWe  out  1  memory write enable.
- MemAddr  out  ADDR_W  word address.
- MemWrData  out  32  write word.
- MemRdData  in  32  read data, valid one cycle after MemEn && !MemWe.

## Operation
- States: BOOT (reset state), RUN.
  - BOOT: only loader is granted; FetchGnt = 0; CpuStall = 1. LdDone in BOOT -> RUN next edge. LdDone in RUN ignored.
  - RUN: fetch has priority. Loader granted when FetchReq = 0, or when WaitCnt == MAX_WAIT (then loader granted, fetch not granted, CpuStall = 1 that cycle).
- WaitCnt (4 bits): in RUN, increments each cycle LdReq = 1 and LdGnt = 0; clears on LdGnt or LdReq = 0; saturates at MAX_WAIT. Held at 0 in BOOT.
- Grants combinational from registered state, WaitCnt and current requests; at most one grant per cycle. A requester holds Req/Addr/Data stable until its Gnt.
- Address check per granted access: Addr[1:0] != 0 or Addr[31:ADDR_W+2] != 0 -> error. Error access: MemEn = 0, no write occurs, response one cycle later with Err = 1, data = 0.
- Good access: MemEn = 1, MemWe = LdWe (0 for fetch), MemAddr = Addr[ADDR_W+1:2], MemWrData = LdWrData.
- Response routing: registered owner tag (fetch/loader) and is-read flag; Valid = 1 next cycle for reads (and errored writes for LdErr); Data = MemRdData. Successful writes produce no LdValid.
- MemEn = 0 and MemWe = 0 when no grant.

## Timing
- Reset (async assert, sync-irrelevant): state = BOOT, WaitCnt = 0, FetchValid = LdValid = FetchErr = LdErr = 0, FetchData = LdRdData = 0, CpuStall = 1, FetchGnt = LdGnt = 0, MemEn = MemWe = 0, MemAddr = 0, MemWrData = 0.
- Read latency: Gnt in cycle N -> Valid/Data in cycle N+1, exactly one cycle. Back-to-back grants allowed every cycle (throughput 1 access/cycle).
- Write: committed at edge ending grant cycle; a read of the same address granted the next cycle returns the new data.
- Same-cycle FetchReq and LdReq in RUN, WaitCnt < MAX_WAIT: fetch wins. WaitCnt == MAX_WAIT: loader wins, WaitCnt -> 0.
- LdDone coincident with a loader grant in BOOT: grant completes; RUN begins next cycle; response still delivered.
- Reset asserted mid-access: pending response discarded; no Valid after release.
- CpuStall in RUN = FetchReq && !FetchGnt.

## Test plan
- Reset, loader writes 0x20080005 to byte addr 0x0 and 0x2009000A to 0x4 in BOOT with FetchReq = 1 -> FetchGnt = 0, CpuStall = 1 throughout; LdDone -> RUN; fetch 0x4 -> FetchValid next cycle, FetchData = 0x2009000A.
- RUN, FetchReq held 1 every cycle, LdReq read 0x0 with MAX_WAIT = 4 -> LdGnt in 5th request cycle, LdValid next cycle with 0x20080005; fetch stalled exactly that one cycle.
- Fetch addr 0x6 -> FetchErr = 1, FetchData = 0, MemEn = 0; fetch addr 0x400 (ADDR_W = 8) -> FetchErr = 1.
- Loader write 0xDEADBEEF to 0x3FC granted cycle N, fetch 0x3FC cycle N+1 -> FetchData = 0xDEADBEEF at N+2.
- Back-to-back fetches 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive FetchValid cycles with matching words.
- RST_n low during a granted read -> no FetchValid after release; state BOOT, CpuStall = 1.

Source files
------------

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_port_arbiter                                             |
// | Purpose  : Shares a single-port 2^ADDR_W x 32 sync-read instruction      |
// |            memory between CPU fetch and the boot/debug loader.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module imem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              FetchReq,
  input  logic [31:0]       FetchAddr,
  output logic              FetchGnt,
  output logic              FetchValid,
  output logic [31:0]       FetchData,
  output logic              FetchErr,
  output logic              CpuStall,
  input  logic              LdReq,
  input  logic              LdWe,
  input  logic [31:0]       LdAddr,
  input  logic [31:0]       LdWrData,
  input  logic              LdDone,
  output logic              LdGnt,
  output logic              LdValid,
  output logic [31:0]       LdRdData,
  output logic              LdErr,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] c_maxWait = 4'(MAX_WAIT);

  state_t      r_state;
  logic [3:0]  r_waitCnt;
  logic        r_rspValid;
  logic        r_rspFetch;
  logic        r_rspRead;
  logic        r_rspErr;

  logic        w_inRun;
  logic        w_preempt;
  logic        w_fetchGnt;
  logic        w_ldGnt;
  logic        w_anyGnt;
  logic [31:0] w_accAddr;
  logic        w_accBad;
  logic        w_memOk;
  logic [31:0] w_rspData;

  function automatic logic badAddr(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
  endfunction

  // Grants are gated by RST_n so nothing is granted while reset is held.
  always_comb begin
    w_inRun    = (r_state == ST_RUN);
    w_preempt  = w_inRun && LdReq && (r_waitCnt == c_maxWait);
    w_fetchGnt = RST_n && w_inRun && FetchReq && !w_preempt;
    w_ldGnt    = RST_n && LdReq && (!w_inRun || !FetchReq || w_preempt);
    w_anyGnt   = w_fetchGnt || w_ldGnt;
    w_accAddr  = w_ldGnt ? LdAddr : FetchAddr;
    w_accBad   = badAddr(w_accAddr);
    w_memOk    = w_anyGnt && !w_accBad;
  end

  always_comb begin
    FetchGnt  = w_fetchGnt;
    LdGnt     = w_ldGnt;
    CpuStall  = !w_inRun || (FetchReq && !w_fetchGnt);
    MemEn     = w_memOk;
    MemWe     = w_memOk && w_ldGnt && LdWe;
    MemAddr   = w_memOk ? w_accAddr[ADDR_W+1:2] : '0;
    MemWrData = w_memOk ? LdWrData : '0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= ST_BOOT;
      r_waitCnt  <= '0;
      r_rspValid <= 1'b0;
      r_rspFetch <= 1'b0;
      r_rspRead  <= 1'b0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: if (LdDone) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase

      // Counts consecutive cycles the loader has been refused in RUN.
      if (!w_inRun || !LdReq || w_ldGnt) begin
        r_waitCnt <= '0;
      end else if (r_waitCnt != c_maxWait) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end

      r_rspValid <= w_anyGnt;
      r_rspFetch <= w_fetchGnt;
      r_rspRead  <= w_fetchGnt || !LdWe;
      r_rspErr   <= w_accBad;
    end
  end

  // Errored accesses never touched the memory, so their data is forced to 0.
  always_comb begin
    w_rspData  = (r_rspValid && r_rspRead && !r_rspErr) ? MemRdData : '0;
    FetchValid = r_rspValid && r_rspFetch;
    FetchErr   = r_rspValid && r_rspFetch && r_rspErr;
    FetchData  = r_rspFetch ? w_rspData : '0;
    LdValid    = r_rspValid && !r_rspFetch && (r_rspRead || r_rspErr);
    LdErr      = r_rspValid && !r_rspFetch && r_rspErr;
    LdRdData   = r_rspFetch ? '0 : w_rspData;
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_port_arbiter                                          |
// | Purpose  : Self-checking bench: directed vector table, corner sequences  |
// |            and random traffic against a behavioural reference model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_imem_port_arbiter;
  localparam int ADDR_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              FetchReq = 1'b0;
  logic [31:0]       FetchAddr = '0;
  logic              FetchGnt, FetchValid, FetchErr, CpuStall;
  logic [31:0]       FetchData;
  logic              LdReq = 1'b0, LdWe = 1'b0, LdDone = 1'b0;
  logic [31:0]       LdAddr = '0, LdWrData = '0;
  logic              LdGnt, LdValid, LdErr;
  logic [31:0]       LdRdData;
  logic              MemEn, MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWrData, MemRdData;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt), .FetchValid(FetchValid),
    .FetchData(FetchData), .FetchErr(FetchErr), .CpuStall(CpuStall),
    .LdReq(LdReq), .LdWe(LdWe), .LdAddr(LdAddr), .LdWrData(LdWrData), .LdDone(LdDone),
    .LdGnt(LdGnt), .LdValid(LdValid), .LdRdData(LdRdData), .LdErr(LdErr),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 CLK = ~CLK;

  // Single-port synchronous-read memory macro; memInit fills it with seed*(i+1).
  logic [31:0] macroMem [DEPTH];
  logic [31:0] macroRd = '0;
  logic        memInit = 1'b0;
  logic [31:0] memSeed = '0;
  always @(posedge CLK) begin
    if (memInit) begin
      for (int i = 0; i < DEPTH; i++) macroMem[i] <= memSeed * 32'(i + 1);
      macroRd <= '0;
    end else if (MemEn) begin
      if (MemWe) macroMem[MemAddr] <= MemWrData;
      else       macroRd <= macroMem[MemAddr];
    end
  end
  assign MemRdData = macroRd;

  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fReq;  logic [31:0] fAddr;
    logic        lReq;  logic lWe; logic [31:0] lAddr; logic [31:0] lData; logic lDone;
    logic        eFGnt, eLGnt, eStall, eEn, eWe; logic [7:0] eMAddr;
    logic        eFV, eFErr; logic [31:0] eFData;
    logic        eLV, eLErr; logic [31:0] eLData;
  } vec_t;
  vec_t vq[$];

  task automatic addVec(input logic fReq, input logic [31:0] fAddr, input logic lReq, input logic lWe,
                        input logic [31:0] lAddr, input logic [31:0] lData, input logic lDone,
                        input logic eFGnt, input logic eLGnt, input logic eStall, input logic eEn,
                        input logic eWe, input logic [7:0] eMAddr,
                        input logic eFV, input logic eFErr, input logic [31:0] eFData,
                        input logic eLV, input logic eLErr, input logic [31:0] eLData);
    vec_t v;
    v.fReq = fReq; v.fAddr = fAddr; v.lReq = lReq; v.lWe = lWe; v.lAddr = lAddr; v.lData = lData;
    v.lDone = lDone; v.eFGnt = eFGnt; v.eLGnt = eLGnt; v.eStall = eStall; v.eEn = eEn; v.eWe = eWe;
    v.eMAddr = eMAddr; v.eFV = eFV; v.eFErr = eFErr; v.eFData = eFData;
    v.eLV = eLV; v.eLErr = eLErr; v.eLData = eLData;
    vq.push_back(v);
  endtask

  task automatic checkResetOutputs(input string tag);
    chkBit({tag, " FetchGnt"}, FetchGnt, 1'b0);
    chkBit({tag, " LdGnt"}, LdGnt, 1'b0);
    chkBit({tag, " CpuStall"}, CpuStall, 1'b1);
    chkBit({tag, " MemEn"}, MemEn, 1'b0);
    chkBit({tag, " MemWe"}, MemWe, 1'b0);
    chk32({tag, " MemAddr"}, 32'(MemAddr), 32'h0);
    chk32({tag, " MemWrData"}, MemWrData, 32'h0);
    chkBit({tag, " FetchValid"}, FetchValid, 1'b0);
    chkBit({tag, " FetchErr"}, FetchErr, 1'b0);
    chk32({tag, " FetchData"}, FetchData, 32'h0);
    chkBit({tag, " LdValid"}, LdValid, 1'b0);
    chkBit({tag, " LdErr"}, LdErr, 1'b0);
    chk32({tag, " LdRdData"}, LdRdData, 32'h0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 15))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      2, 3:    return 32'($urandom_range(0, DEPTH - 1) * 4);
      default: return 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  // Reference model state
  bit          mBoot;
  int          mWait;
  logic [31:0] refMem [DEPTH];
  bit          pV, pFetch, pRead, pErr;
  logic [31:0] pData;

  initial begin
    // ---------------- reset and directed vector table ----------------
    memSeed = 32'h0;
    memInit = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    memInit = 1'b0;
    @(negedge CLK);
    checkResetOutputs("reset");
    @(posedge CLK); #1;
    RST_n = 1'b1;

    // BOOT: loader writes while fetch is held off
    addVec(1'b1, 32'h4,   1'b1, 1'b1, 32'h0,   32'h20080005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h4,   1'b1, 1'b1, 32'h4,   32'h2009000A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h4,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // RUN: fetch, misaligned, out of range
    addVec(1'b1, 32'h4,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h6,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h2009000A, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    // write then read-after-write at the top word
    addVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h3FC, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // back-to-back fetches
    addVec(1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h4,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 32'h20080005, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 32'h2009000A, 1'b0, 1'b0, 32'h0);
    // starvation: loader refused four cycles, wins the fifth
    for (int k = 0; k < 4; k++)
      addVec(1'b1, 32'h8, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h8,   1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20080005);
    // loader write with bad address, then LdDone in RUN is ignored
    addVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h2,   32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    addVec(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    addVec(1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int r = 0; r < vq.size(); r++) begin
      FetchReq = vq[r].fReq; FetchAddr = vq[r].fAddr;
      LdReq = vq[r].lReq; LdWe = vq[r].lWe; LdAddr = vq[r].lAddr; LdWrData = vq[r].lData;
      LdDone = vq[r].lDone;
      @(negedge CLK);
      chkBit($sformatf("v%0d FetchGnt", r), FetchGnt, vq[r].eFGnt);
      chkBit($sformatf("v%0d LdGnt", r), LdGnt, vq[r].eLGnt);
      chkBit($sformatf("v%0d CpuStall", r), CpuStall, vq[r].eStall);
      chkBit($sformatf("v%0d MemEn", r), MemEn, vq[r].eEn);
      chkBit($sformatf("v%0d MemWe", r), MemWe, vq[r].eWe);
      chk32($sformatf("v%0d MemAddr", r), 32'(MemAddr), 32'(vq[r].eMAddr));
      chkBit($sformatf("v%0d FetchValid", r), FetchValid, vq[r].eFV);
      chkBit($sformatf("v%0d FetchErr", r), FetchErr, vq[r].eFErr);
      chk32($sformatf("v%0d FetchData", r), FetchData, vq[r].eFData);
      chkBit($sformatf("v%0d LdValid", r), LdValid, vq[r].eLV);
      chkBit($sformatf("v%0d LdErr", r), LdErr, vq[r].eLErr);
      chk32($sformatf("v%0d LdRdData", r), LdRdData, vq[r].eLData);
      @(posedge CLK); #1;
    end

    // ---------------- reset during a granted read ----------------
    FetchReq = 1'b1; FetchAddr = 32'h4; LdReq = 1'b0; LdDone = 1'b0;
    @(negedge CLK);
    chkBit("rstmid gnt before reset", FetchGnt, 1'b1);
    chkBit("rstmid prev FetchValid", FetchValid, 1'b1);
    chk32("rstmid prev FetchData", FetchData, 32'h20080005);
    #1 RST_n = 1'b0;
    #1 checkResetOutputs("rstmid");
    @(posedge CLK); @(posedge CLK); #1;
    RST_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chkBit("rstmid FetchValid after release", FetchValid, 1'b0);
      chkBit("rstmid FetchGnt in BOOT", FetchGnt, 1'b0);
      chkBit("rstmid CpuStall in BOOT", CpuStall, 1'b1);
      @(posedge CLK); #1;
    end

    // ---------------- LdDone coincident with a loader read grant ----------------
    FetchReq = 1'b0; LdReq = 1'b1; LdWe = 1'b0; LdAddr = 32'h3FC; LdDone = 1'b1;
    @(negedge CLK);
    chkBit("lddone LdGnt", LdGnt, 1'b1);
    @(posedge CLK); #1;
    LdReq = 1'b0; LdDone = 1'b0; FetchReq = 1'b1; FetchAddr = 32'h0;
    @(negedge CLK);
    chkBit("lddone LdValid", LdValid, 1'b1);
    chk32("lddone LdRdData", LdRdData, 32'hDEADBEEF);
    chkBit("lddone FetchGnt in RUN", FetchGnt, 1'b1);
    chkBit("lddone CpuStall", CpuStall, 1'b0);
    @(posedge CLK); #1;
    FetchReq = 1'b0;
    @(negedge CLK);
    chk32("lddone FetchData", FetchData, 32'h20080005);
    @(posedge CLK); #1;

    // ---------------- randomized traffic vs reference model ----------------
    RST_n = 1'b0;
    memSeed = $urandom | 32'h1;
    memInit = 1'b1;
    for (int i = 0; i < DEPTH; i++) refMem[i] = memSeed * 32'(i + 1);
    @(posedge CLK); #1;
    memInit = 1'b0;
    RST_n = 1'b1;
    mBoot = 1'b1; mWait = 0; pV = 1'b0; pFetch = 1'b0; pRead = 1'b0; pErr = 1'b0; pData = '0;
    begin
      bit fHold, lHold, eFGnt, eLGnt, bad, good;
      logic [31:0] addr;
      fHold = 1'b0; lHold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 1000 == 999) begin
          RST_n = 1'b0;
          @(posedge CLK); #1;
          RST_n = 1'b1;
          mBoot = 1'b1; mWait = 0; pV = 1'b0; fHold = 1'b0; lHold = 1'b0;
        end
        if (!fHold) begin FetchReq = ($urandom_range(0, 3) != 0); FetchAddr = randAddr(); end
        if (!lHold) begin
          LdReq = ($urandom_range(0, 2) == 0); LdWe = 1'($urandom_range(0, 1));
          LdAddr = randAddr(); LdWrData = $urandom;
        end
        LdDone = ($urandom_range(0, 39) == 0);
        @(negedge CLK);

        // Loader is guaranteed a slot once it has been refused MAX_WAIT times in RUN.
        eLGnt = LdReq && (mBoot || !FetchReq || mWait >= MAX_WAIT);
        eFGnt = !mBoot && FetchReq && !eLGnt;
        addr  = eLGnt ? LdAddr : FetchAddr;
        bad   = (addr % 4 != 0) || (addr >= DEPTH * 4);
        good  = (eLGnt || eFGnt) && !bad;

        chkBit("rnd FetchGnt", FetchGnt, eFGnt);
        chkBit("rnd LdGnt", LdGnt, eLGnt);
        chkBit("rnd CpuStall", CpuStall, mBoot || (FetchReq && !eFGnt));
        chkBit("rnd MemEn", MemEn, good);
        chkBit("rnd MemWe", MemWe, good && eLGnt && LdWe);
        chk32("rnd MemAddr", 32'(MemAddr), good ? addr / 4 : 32'h0);
        if (good && eLGnt && LdWe) chk32("rnd MemWrData", MemWrData, LdWrData);
        chkBit("rnd FetchValid", FetchValid, pV && pFetch);
        chkBit("rnd FetchErr", FetchErr, pV && pFetch && pErr);
        chk32("rnd FetchData", FetchData, (pV && pFetch && !pErr) ? pData : 32'h0);
        chkBit("rnd LdValid", LdValid, pV && !pFetch && (pRead || pErr));
        chkBit("rnd LdErr", LdErr, pV && !pFetch && pErr);
        chk32("rnd LdRdData", LdRdData, (pV && !pFetch && pRead && !pErr) ? pData : 32'h0);

        pV     = eLGnt || eFGnt;
        pFetch = eFGnt;
        pRead  = eFGnt || !LdWe;
        pErr   = bad;
        pData  = bad ? 32'h0 : refMem[addr / 4];
        if (good && eLGnt && LdWe) refMem[addr / 4] = LdWrData;
        if (!mBoot && LdReq && !eLGnt) mWait = (mWait + 1 > MAX_WAIT) ? MAX_WAIT : mWait + 1;
        else mWait = 0;
        if (mBoot && LdDone) mBoot = 1'b0;
        fHold = FetchReq && !eFGnt;
        lHold = LdReq && !eLGnt;
        @(posedge CLK); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
